// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link: word width, length-code width and
// the deserializer state type. Length code 0 means a full DATA_W-bit word.
package serdes_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_MOD_W  = $clog2(DEF_DATA_W);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_e;

endpackage : serdes_pkg

// File: rtl/deser_shift_reg.sv
// Indexed bit-insert register: each written bit lands at DATA_W-1-cnt, so the
// first bit of a word ends up in the MSB. Synchronous clear wins over write.
module deser_shift_reg
  import serdes_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      clr,
  input  logic                      wr,
  input  logic                      din,
  output logic [DATA_W-1:0]         data,
  output logic [DATA_W-1:0]         ins_data,
  output logic [$clog2(DATA_W):0]   cnt
);

  localparam int MOD_W = $clog2(DATA_W);

  logic [MOD_W-1:0] pos;

  // DATA_W is a power of two, so the low MOD_W bits of cnt fully address the word.
  assign pos = MOD_W'(DATA_W - 1) - cnt[MOD_W-1:0];

  // NOTE: give every always_comb output a full default first, or a latch is inferred.
  always_comb begin
    ins_data      = data;
    ins_data[pos] = din;
  end

  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (wr) begin
      data <= ins_data;
      cnt  <= cnt + (MOD_W + 1)'(1);
    end
  end

endmodule : deser_shift_reg

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: MSB-first bits, words end on DATA_W bits or on
// a strobe gap, published with a registered one-cycle valid and length code.
module deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o
);

  deser_state_e      state;
  logic [DATA_W-1:0] sr_data;
  logic [DATA_W-1:0] sr_ins_data;
  logic [MOD_W:0]    cnt;
  logic              last_bit;
  logic              sr_clr;

  assign last_bit = (cnt == (MOD_W + 1)'(DATA_W - 1));
  // Any word end (full or gap) empties the register so the next bit starts at the MSB.
  assign sr_clr   = (state == RECV) && (!ser_data_val_i || last_bit);

  deser_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift_reg (
    .clk      (clk_i),
    .arst     (arst_i),
    .clr      (sr_clr),
    .wr       (ser_data_val_i),
    .din      (ser_data_i),
    .data     (sr_data),
    .ins_data (sr_ins_data),
    .cnt      (cnt)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state            <= IDLE;
      deser_data_o     <= '0;
      deser_mod_o      <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ser_data_val_i) state <= RECV;
        end
        RECV: begin
          if (!ser_data_val_i) begin
            deser_data_o     <= sr_data;
            deser_mod_o      <= cnt[MOD_W-1:0];
            deser_data_val_o <= 1'b1;
            state            <= IDLE;
          end else if (last_bit) begin
            deser_data_o     <= sr_ins_data;
            deser_mod_o      <= '0;
            deser_data_val_o <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : deserializer
